led_refresh_ctrl: RTL and testbench

Frame scheduler for the serial LED transmitter (LED_send). It owns a double-buffered pixel store: requesters write a shadow buffer, and a commit copies it into the active buffer. Transfers are kicked either by a commit or by a periodic refresh timer. It drives the transmitter's one-cycle enable/data interface and tracks completion through the transmitter's busy indication.

---
 rtl/led_refresh_ctrl_if.sv | 28 ++
 rtl/led_refresh_ctrl.sv | 150 +++++++++++++++
 tb/tb_led_refresh_ctrl.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/led_refresh_ctrl_if.sv
// Requester write/commit port and LED transmitter handshake for led_refresh_ctrl.
// The slave modport is the controller; master is whoever drives requests and models the phy.
interface led_refresh_ctrl_if #(
  parameter int unsigned LED_NUM = 4,
  parameter int unsigned AW      = (LED_NUM > 1) ? $clog2(LED_NUM) : 1
) ();
  logic                   wr_en;
  logic [AW-1:0]          wr_addr;
  logic [23:0]            wr_data;
  logic [4:0]             wr_bright;
  logic                   commit;
  logic                   phy_en;
  logic [32*LED_NUM-1:0]  phy_data;
  logic                   phy_busy;
  logic                   frame_done;
  logic                   sending;
  logic                   err_timeout;

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_bright, commit, phy_busy,
    output phy_en, phy_data, frame_done, sending, err_timeout
  );

  modport master (
    output wr_en, wr_addr, wr_data, wr_bright, commit, phy_busy,
    input  phy_en, phy_data, frame_done, sending, err_timeout
  );
endinterface

// File: rtl/led_refresh_ctrl.sv
// Double-buffered LED frame scheduler driving the serial LED transmitter.
// Define LED_REFRESH_TIMER_EN to add the periodic refresh timer (REFRESH_CNT cycles).
module led_refresh_ctrl #(
  parameter int unsigned LED_NUM      = 4,
  parameter int unsigned AW           = (LED_NUM > 1) ? $clog2(LED_NUM) : 1,
  parameter int unsigned REFRESH_CNT  = 1500000,
  parameter int unsigned BUSY_TIMEOUT = 64
) (
  input logic               clk,
  input logic               rstn,
  led_refresh_ctrl_if.slave bus
);

  localparam logic [31:0] PixRst = 32'hE000_0000;
  localparam int unsigned TW     = 7;

  typedef enum logic [1:0] {StIdle, StKick, StWaitBusy, StWaitDone} state_e;

  state_e        state_q;
  logic [31:0]   shadow_q [LED_NUM];
  logic [31:0]   active_q [LED_NUM];
  logic [31:0]   merged   [LED_NUM];
  logic [TW-1:0] to_cnt_q;
  logic          commit_pend_q;
  logic          phy_en_q;
  logic          frame_done_q;
  logic          sending_q;
  logic          err_timeout_q;
  logic          refresh_pend;
  logic          wr_valid;
  logic [31:0]   wr_word;

  assign wr_valid = bus.wr_en && (32'(bus.wr_addr) < LED_NUM);
  assign wr_word  = {3'b111, bus.wr_bright, bus.wr_data};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < LED_NUM; i++) shadow_q[i] <= PixRst;
    end else if (wr_valid) begin
      shadow_q[bus.wr_addr] <= wr_word;
    end
  end

  // A write landing on the copy edge must appear in the published frame.
  always_comb begin
    for (int unsigned i = 0; i < LED_NUM; i++) begin
      merged[i] = (wr_valid && (bus.wr_addr == AW'(i))) ? wr_word : shadow_q[i];
    end
  end

`ifdef LED_REFRESH_TIMER_EN
  localparam int unsigned RW = (REFRESH_CNT > 1) ? $clog2(REFRESH_CNT) : 1;

  logic [RW-1:0] ref_cnt_q;
  logic          ref_wrap;
  logic          refresh_pend_q;

  assign ref_wrap = (ref_cnt_q == RW'(REFRESH_CNT - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ref_cnt_q <= '0;
    end else begin
      ref_cnt_q <= ref_wrap ? '0 : ref_cnt_q + RW'(1);
    end
  end

  // A wrap coinciding with a kick is kept so the next period is not lost.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      refresh_pend_q <= 1'b0;
    end else if (ref_wrap) begin
      refresh_pend_q <= 1'b1;
    end else if (state_q == StKick) begin
      refresh_pend_q <= 1'b0;
    end
  end

  assign refresh_pend = refresh_pend_q;
`else
  assign refresh_pend = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= StIdle;
      phy_en_q      <= 1'b0;
      frame_done_q  <= 1'b0;
      sending_q     <= 1'b0;
      err_timeout_q <= 1'b0;
      commit_pend_q <= 1'b0;
      to_cnt_q      <= '0;
      for (int unsigned i = 0; i < LED_NUM; i++) active_q[i] <= PixRst;
    end else begin
      phy_en_q     <= 1'b0;
      frame_done_q <= 1'b0;
      if (bus.commit) commit_pend_q <= 1'b1;
      unique case (state_q)
        StIdle: begin
          // frame_done_q blocks the kick so an idle cycle always follows a completion.
          if ((commit_pend_q || refresh_pend) && !bus.phy_busy && !frame_done_q) begin
            state_q   <= StKick;
            phy_en_q  <= 1'b1;
            sending_q <= 1'b1;
            if (commit_pend_q) begin
              active_q      <= merged;
              commit_pend_q <= bus.commit;
            end
          end
        end
        StKick: begin
          state_q  <= StWaitBusy;
          to_cnt_q <= '0;
        end
        StWaitBusy: begin
          if (bus.phy_busy) begin
            state_q <= StWaitDone;
          end else if (to_cnt_q == TW'(BUSY_TIMEOUT - 1)) begin
            err_timeout_q <= 1'b1;
            sending_q     <= 1'b0;
            state_q       <= StIdle;
          end else if (to_cnt_q != '1) begin
            to_cnt_q <= to_cnt_q + TW'(1);
          end
        end
        StWaitDone: begin
          if (!bus.phy_busy) begin
            frame_done_q <= 1'b1;
            sending_q    <= 1'b0;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    bus.phy_data = '0;
    for (int unsigned i = 0; i < LED_NUM; i++) begin
      bus.phy_data[32*(LED_NUM-i)-1 -: 32] = active_q[i];
    end
  end

  assign bus.phy_en      = phy_en_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.sending     = sending_q;
  assign bus.err_timeout = err_timeout_q;

endmodule

// File: tb/tb_led_refresh_ctrl.sv
// Directed bench for led_refresh_ctrl; the refresh-timer section needs LED_REFRESH_TIMER_EN.
module tb_led_refresh_ctrl;

  localparam int unsigned LED_NUM = 4;
  localparam int unsigned AW      = 2;
  localparam logic [127:0] DataRst = {4{32'hE000_0000}};

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  led_refresh_ctrl_if #(.LED_NUM(LED_NUM), .AW(AW)) bus ();

  led_refresh_ctrl #(
    .LED_NUM      (LED_NUM),
    .AW           (AW),
    .REFRESH_CNT  (1500000),
    .BUSY_TIMEOUT (64)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

`ifdef LED_REFRESH_TIMER_EN
  led_refresh_ctrl_if #(.LED_NUM(LED_NUM), .AW(AW)) rbus ();

  led_refresh_ctrl #(
    .LED_NUM      (LED_NUM),
    .AW           (AW),
    .REFRESH_CNT  (100),
    .BUSY_TIMEOUT (64)
  ) dut_ref (
    .clk  (clk),
    .rstn (rstn),
    .bus  (rbus)
  );
`endif

  int n_cmp = 0;
  int n_bad = 0;

  int cyc       = 0;
  int en_cnt    = 0;
  int done_cnt  = 0;
  int last_done = -1000;
  int gap_bad   = 0;

  always @(negedge clk) begin
    cyc++;
    if (bus.phy_en) begin
      en_cnt++;
      if (cyc - last_done < 2) gap_bad++;
    end
    if (bus.frame_done) begin
      done_cnt++;
      last_done = cyc;
    end
  end

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic commit_pulse();
    bus.commit = 1'b1;
    tick();
    bus.commit = 1'b0;
  endtask

  task automatic wait_en(input string tag);
    int n = 0;
    while (!bus.phy_en && n < 20) begin
      tick();
      n++;
    end
    check_val({tag, "_phy_en"}, 128'(bus.phy_en), 128'(1));
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!bus.frame_done && n < 20) begin
      tick();
      n++;
    end
    check_val({tag, "_frame_done"}, 128'(bus.frame_done), 128'(1));
  endtask

  // Called in the phy_en cycle: hold busy for nbusy cycles, then expect completion.
  task automatic finish_xfer(input string tag, input int nbusy);
    bus.phy_busy = 1'b1;
    repeat (nbusy) tick();
    bus.phy_busy = 1'b0;
    wait_done(tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_phy_en"},      128'(bus.phy_en),      128'(0));
    check_val({tag, "_phy_data"},    bus.phy_data,          DataRst);
    check_val({tag, "_frame_done"},  128'(bus.frame_done),  128'(0));
    check_val({tag, "_sending"},     128'(bus.sending),     128'(0));
    check_val({tag, "_err_timeout"}, 128'(bus.err_timeout), 128'(0));
  endtask

  int base_en;
  int base_done;

  initial begin
    bus.wr_en     = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.wr_bright = '0;
    bus.commit    = 1'b0;
    bus.phy_busy  = 1'b0;
`ifdef LED_REFRESH_TIMER_EN
    rbus.wr_en     = 1'b0;
    rbus.wr_addr   = '0;
    rbus.wr_data   = '0;
    rbus.wr_bright = '0;
    rbus.commit    = 1'b0;
    rbus.phy_busy  = 1'b0;
`endif

    repeat (3) tick();
    check_reset_outputs("rst");
    rstn = 1'b1;
    tick();

    // Commit with no writes: phy_en two cycles after the commit cycle.
    commit_pulse();
    check_val("t1_en_early", 128'(bus.phy_en), 128'(0));
    tick();
    check_val("t1_en_latency", 128'(bus.phy_en), 128'(1));
    check_val("t1_data", bus.phy_data, DataRst);
    check_val("t1_sending", 128'(bus.sending), 128'(1));
    finish_xfer("t1", 10);
    check_val("t1_sending_idle", 128'(bus.sending), 128'(0));
    repeat (5) tick();
    check_val("t1_en_count", 128'(en_cnt), 128'(1));
    check_val("t1_done_count", 128'(done_cnt), 128'(1));

    // Pixel 2 write lands in phy_data[63:32].
    bus.wr_en     = 1'b1;
    bus.wr_addr   = 2'd2;
    bus.wr_data   = 24'h0000FF;
    bus.wr_bright = 5'h1F;
    tick();
    bus.wr_en = 1'b0;
    commit_pulse();
    wait_en("t2");
    check_val("t2_word2", 128'(bus.phy_data[63:32]), 128'(32'hFF0000FF));
    check_val("t2_data", bus.phy_data,
              {32'hE000_0000, 32'hE000_0000, 32'hFF0000FF, 32'hE000_0000});
    finish_xfer("t2", 6);
    repeat (3) tick();

    // Commits during WAIT_DONE collapse into exactly one follow-up transfer.
    commit_pulse();
    wait_en("t3");
    bus.phy_busy = 1'b1;
    repeat (3) tick();
    base_en = en_cnt;
    repeat (4) begin
      bus.commit = 1'b1;
      tick();
      bus.commit = 1'b0;
      tick();
    end
    bus.phy_busy = 1'b0;
    wait_done("t3a");
    wait_en("t3b");
    finish_xfer("t3b", 4);
    repeat (20) tick();
    check_val("t3_one_more_en", 128'(en_cnt), 128'(base_en + 1));
    check_val("t3_idle_gap", 128'(gap_bad), 128'(0));

    // Write in the copy cycle is merged into the published frame.
    commit_pulse();
    bus.wr_en     = 1'b1;
    bus.wr_addr   = 2'd0;
    bus.wr_data   = 24'h123456;
    bus.wr_bright = 5'h01;
    tick();
    bus.wr_en = 1'b0;
    check_val("t4_en", 128'(bus.phy_en), 128'(1));
    check_val("t4_word0", 128'(bus.phy_data[127:96]), 128'(32'hE1123456));
    check_val("t4_word2", 128'(bus.phy_data[63:32]), 128'(32'hFF0000FF));
    finish_xfer("t4", 3);
    repeat (3) tick();

    // Busy never rises: error after 64 WAIT_BUSY cycles, no frame_done.
    base_done = done_cnt;
    commit_pulse();
    wait_en("t5");
    repeat (64) tick();
    check_val("t5_err_early", 128'(bus.err_timeout), 128'(0));
    check_val("t5_sending_wait", 128'(bus.sending), 128'(1));
    tick();
    check_val("t5_err", 128'(bus.err_timeout), 128'(1));
    check_val("t5_sending_idle", 128'(bus.sending), 128'(0));
    repeat (3) tick();
    check_val("t5_no_done", 128'(done_cnt), 128'(base_done));
    check_val("t5_err_sticky", 128'(bus.err_timeout), 128'(1));

    // Asynchronous reset in WAIT_DONE restores every output.
    commit_pulse();
    wait_en("t6");
    bus.phy_busy = 1'b1;
    repeat (3) tick();
    check_val("t6_pre_sending", 128'(bus.sending), 128'(1));
    base_done = done_cnt;
    rstn = 1'b0;
    #1;
    check_reset_outputs("t6");
    bus.phy_busy = 1'b0;
    tick();
    rstn = 1'b1;
    repeat (5) tick();
    check_val("t6_no_done", 128'(done_cnt), 128'(base_done));
    check_val("t6_still_idle", 128'(bus.sending), 128'(0));

`ifdef LED_REFRESH_TIMER_EN
    begin
      int en_at [4];
      int n_en = 0;
      int bcnt = 0;
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
      for (int k = 0; k < 330; k++) begin
        tick();
        if (rbus.phy_en) begin
          if (n_en < 4) en_at[n_en] = k;
          n_en++;
          bcnt = 5;
          check_val("t7_ref_data", rbus.phy_data, DataRst);
        end
        rbus.phy_busy = (bcnt > 0);
        if (bcnt > 0) bcnt--;
      end
      check_val("t7_ref_count", 128'(n_en), 128'(3));
      check_val("t7_period_a", 128'(en_at[1] - en_at[0]), 128'(100));
      check_val("t7_period_b", 128'(en_at[2] - en_at[1]), 128'(100));
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
